// File: rtl/sample_unpacker_if.sv
// Stream bundle for sample_unpacker: nibble-tagged word input and triple-sample output.
interface sample_unpacker_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic [15:0]           in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] ch1_out;
  logic [DATA_WIDTH-1:0] ch2_out;
  logic [DATA_WIDTH-1:0] ch3_out;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, ch1_out, ch2_out, ch3_out, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, ch1_out, ch2_out, ch3_out, out_valid
  );
endinterface

// File: rtl/sample_unpacker.sv
// Reassembles four marker-tagged BRAM words into one three-channel sample triplet.
// Optional macro UNPACK_ERRCNT_EN enables the saturating marker-error counter.
module sample_unpacker #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sync,
  sample_unpacker_if.slave        bus,
  output logic                    marker_err,
  output logic [15:0]             frame_count,
  output logic [7:0]              err_count
);

  typedef enum logic [0:0] {StRun, StDrop} state_e;

  state_e                state_q;
  logic [1:0]            idx_q;
  logic [11:0]           asm1_q, asm2_q, asm3_q;
  logic [DATA_WIDTH-1:0] ch1_q, ch2_q, ch3_q;
  logic                  out_valid_q;
  logic                  marker_err_q;
  logic [15:0]           frame_q;

  logic                  rdy;
  logic                  accept;
  logic                  marker_ok;
  logic                  bad_word;
  logic [15:0]           full1, full2, full3;

  // Single output register without skid: stall input whenever the output is occupied.
  assign rdy       = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && rdy;
  assign marker_ok = (bus.in_data[15:12] == 4'hF);
  assign bad_word  = !sync && accept && (state_q == StRun) && !marker_ok;

  // Last nibble completes the sample directly from the input word.
  assign full1 = {asm1_q, bus.in_data[11:8]};
  assign full2 = {asm2_q, bus.in_data[7:4]};
  assign full3 = {asm3_q, bus.in_data[3:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StRun;
      idx_q        <= 2'd0;
      asm1_q       <= '0;
      asm2_q       <= '0;
      asm3_q       <= '0;
      ch1_q        <= '0;
      ch2_q        <= '0;
      ch3_q        <= '0;
      out_valid_q  <= 1'b0;
      marker_err_q <= 1'b0;
      frame_q      <= '0;
    end else begin
      marker_err_q <= 1'b0;
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (sync) begin
        state_q <= StRun;
        idx_q   <= 2'd0;
        asm1_q  <= '0;
        asm2_q  <= '0;
        asm3_q  <= '0;
      end else if (accept) begin
        unique case (state_q)
          StRun: begin
            if (bad_word) begin
              marker_err_q <= 1'b1;
              idx_q        <= 2'd0;
              asm1_q       <= '0;
              asm2_q       <= '0;
              asm3_q       <= '0;
              state_q      <= StDrop;
            end else if (idx_q == 2'd3) begin
              ch1_q       <= full1[DATA_WIDTH-1:0];
              ch2_q       <= full2[DATA_WIDTH-1:0];
              ch3_q       <= full3[DATA_WIDTH-1:0];
              out_valid_q <= 1'b1;
              frame_q     <= frame_q + 16'd1;
              idx_q       <= 2'd0;
            end else begin
              asm1_q <= {asm1_q[7:0], bus.in_data[11:8]};
              asm2_q <= {asm2_q[7:0], bus.in_data[7:4]};
              asm3_q <= {asm3_q[7:0], bus.in_data[3:0]};
              idx_q  <= idx_q + 2'd1;
            end
          end
          StDrop: begin
            state_q <= StDrop;
          end
          default: state_q <= StRun;
        endcase
      end
    end
  end

`ifdef UNPACK_ERRCNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
    end else if (bad_word && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

  assign bus.in_ready  = rdy;
  assign bus.ch1_out   = ch1_q;
  assign bus.ch2_out   = ch2_q;
  assign bus.ch3_out   = ch3_q;
  assign bus.out_valid = out_valid_q;
  assign marker_err    = marker_err_q;
  assign frame_count   = frame_q;

endmodule

// File: tb/tb_sample_unpacker.sv
// Bench for sample_unpacker: directed vector table, corner sequences and random traffic
// checked against a word-queue reference model; 16-bit and 12-bit instances run in lockstep.
module tb_sample_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sync = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_data = '0;

  always #5 clk = ~clk;

  sample_unpacker_if #(.DATA_WIDTH(16)) bus16 ();
  sample_unpacker_if #(.DATA_WIDTH(12)) bus12 ();

  assign bus16.in_data   = in_data;
  assign bus16.in_valid  = in_valid;
  assign bus16.out_ready = out_ready;
  assign bus12.in_data   = in_data;
  assign bus12.in_valid  = in_valid;
  assign bus12.out_ready = out_ready;

  logic        merr16, merr12;
  logic [15:0] fc16, fc12;
  logic [7:0]  ec16, ec12;

  sample_unpacker #(.DATA_WIDTH(16)) dut16 (
    .clk         (clk),
    .rst         (rst),
    .sync        (sync),
    .bus         (bus16),
    .marker_err  (merr16),
    .frame_count (fc16),
    .err_count   (ec16)
  );

  sample_unpacker #(.DATA_WIDTH(12)) dut12 (
    .clk         (clk),
    .rst         (rst),
    .sync        (sync),
    .bus         (bus12),
    .marker_err  (merr12),
    .frame_count (fc12),
    .err_count   (ec12)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted words are collected per group, samples computed arithmetically.
  logic [15:0] grp [$];
  logic [47:0] exp_q [$];
  bit          m_drop = 1'b0;
  bit          m_merr = 1'b0;
  logic [15:0] m_frames = '0;
  int          m_errs = 0;

  function automatic logic [31:0] exp_err_count();
`ifdef UNPACK_ERRCNT_EN
    return (m_errs > 255) ? 32'd255 : 32'(m_errs);
`else
    return 32'd0;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      grp.delete();
      exp_q.delete();
      m_drop   = 1'b0;
      m_merr   = 1'b0;
      m_frames = '0;
      m_errs   = 0;
    end else begin
      bit          ov;
      bit          ir;
      bit          acc;
      logic [47:0] t;
      logic [15:0] s1, s2, s3;
      ov = (exp_q.size() != 0);
      ir = !ov || out_ready;
      chk("out_valid", bus16.out_valid, ov);
      chk("out_valid12", bus12.out_valid, ov);
      chk("in_ready", bus16.in_ready, ir);
      chk("in_ready12", bus12.in_ready, ir);
      chk("marker_err", merr16, m_merr);
      chk("marker_err12", merr12, m_merr);
      chk("frame_count", fc16, m_frames);
      chk("frame_count12", fc12, m_frames);
      chk("err_count", ec16, exp_err_count());
      chk("err_count12", ec12, exp_err_count());
      if (ov) begin
        t = exp_q[0];
        chk("ch1", bus16.ch1_out, t[47:32]);
        chk("ch2", bus16.ch2_out, t[31:16]);
        chk("ch3", bus16.ch3_out, t[15:0]);
        chk("ch1_12", bus12.ch1_out, t[43:32]);
        chk("ch2_12", bus12.ch2_out, t[27:16]);
        chk("ch3_12", bus12.ch3_out, t[11:0]);
        if (out_ready) void'(exp_q.pop_front());
      end
      acc    = in_valid && ir;
      m_merr = 1'b0;
      if (sync) begin
        grp.delete();
        m_drop = 1'b0;
      end else if (acc && !m_drop) begin
        if (in_data[15:12] != 4'hF) begin
          m_merr = 1'b1;
          m_errs++;
          grp.delete();
          m_drop = 1'b1;
        end else begin
          grp.push_back(in_data);
          if (grp.size() == 4) begin
            s1 = '0; s2 = '0; s3 = '0;
            for (int k = 0; k < 4; k++) begin
              s1 = s1 * 16 + 16'(grp[k][11:8]);
              s2 = s2 * 16 + 16'(grp[k][7:4]);
              s3 = s3 * 16 + 16'(grp[k][3:0]);
            end
            exp_q.push_back({s1, s2, s3});
            m_frames = m_frames + 16'd1;
            grp.delete();
          end
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_word(input logic [15:0] w);
    int n;
    n        = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!bus16.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: in_ready stuck at 0 expected 1 for word %h", w);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_sync();
    sync     = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    sync = 1'b0;
  endtask

  task automatic send_group(input logic [63:0] ws);
    for (int k = 0; k < 4; k++) send_word(ws[63-16*k -: 16]);
  endtask

  typedef struct {
    logic [63:0] words;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] e3;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{words: 64'hF123_F456_F789_FABC, e1: 16'h147A, e2: 16'h258B, e3: 16'h369C};
    vecs[1] = '{words: 64'hF000_F000_F000_F000, e1: 16'h0000, e2: 16'h0000, e3: 16'h0000};
    vecs[2] = '{words: 64'hFFFF_FFFF_FFFF_FFFF, e1: 16'hFFFF, e2: 16'hFFFF, e3: 16'hFFFF};
    vecs[3] = '{words: 64'hF1A5_F2B6_F3C7_F4D8, e1: 16'h1234, e2: 16'hABCD, e3: 16'h5678};

    #2;
    chk("rst_in_ready", bus16.in_ready, 1);
    chk("rst_out_valid", bus16.out_valid, 0);
    chk("rst_ch1", bus16.ch1_out, 0);
    chk("rst_marker_err", merr16, 0);
    chk("rst_frame_count", fc16, 0);
    chk("rst_err_count", ec16, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      pulse_sync();
      send_group(vecs[i].words);
      @(negedge clk);
      chk("vec_ch1", bus16.ch1_out, vecs[i].e1);
      chk("vec_ch2", bus16.ch2_out, vecs[i].e2);
      chk("vec_ch3", bus16.ch3_out, vecs[i].e3);
      chk("vec12_ch1", bus12.ch1_out, vecs[i].e1[11:0]);
      chk("vec12_ch3", bus12.ch3_out, vecs[i].e3[11:0]);
      @(posedge clk);
      #1;
    end

    // Bad marker enters DROP until sync.
    pulse_sync();
    send_word(16'hF123);
    send_word(16'h0456);
    @(negedge clk);
    chk("err_pulse", merr16, 1);
    chk("err_count_one", ec16, exp_err_count());
    @(posedge clk);
    #1;
    send_group(64'hF111_F222_F333_F444);
    @(negedge clk);
    chk("drop_no_out", bus16.out_valid, 0);
    @(posedge clk);
    #1;
    pulse_sync();
    send_group(vecs[0].words);
    @(negedge clk);
    chk("resync_ch1", bus16.ch1_out, 16'h147A);
    @(posedge clk);
    #1;

    // Backpressure: second group stalls until the first triplet is taken.
    out_ready = 1'b0;
    send_group(64'hF159_F26A_F37B_F48C);
    in_data  = 16'hF9D1;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", bus16.in_ready, 0);
      chk("bp_hold_ch1", bus16.ch1_out, 16'h1234);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_group(64'hF9D1_FAE2_FBF3_FC04);
    @(negedge clk);
    chk("bp_second_ch2", bus16.ch2_out, 16'hDEF0);
    @(posedge clk);
    #1;

    // sync on the third word discards the partial group.
    pulse_sync();
    send_word(16'hF111);
    send_word(16'hF222);
    sync     = 1'b1;
    in_data  = 16'hF333;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    sync     = 1'b0;
    in_valid = 1'b0;
    send_group(vecs[0].words);
    @(negedge clk);
    chk("sync_mid_ch3", bus16.ch3_out, 16'h369C);
    @(posedge clk);
    #1;

    // Reset mid-group loses the partial data.
    send_word(16'hF123);
    send_word(16'hF456);
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_group(vecs[3].words);
    @(negedge clk);
    chk("rst_mid_ch2", bus16.ch2_out, 16'hABCD);
    chk("rst_mid_frames", fc16, 1);
    @(posedge clk);
    #1;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sync      = ($urandom_range(0, 63) == 0);
      in_data   = {(($urandom_range(0, 31) == 0) ? 4'h0 : 4'hF), 12'($urandom)};
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    sync      = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Saturation of the error counter.
    for (int e = 0; e < 300; e++) begin
      pulse_sync();
      send_word(16'h0BAD);
    end
    @(negedge clk);
    chk("err_saturate", ec16, exp_err_count());
`ifdef UNPACK_ERRCNT_EN
    chk("err_saturate_ff", ec16, 8'hFF);
`else
    chk("err_disabled_zero", ec16, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
